// File: rtl/fnd_scan_controller.sv
// Purpose : time-multiplexed 4-digit FND scanner; cycles digits 0..3 with a blanking gap
//           after each lit slot and double-buffers the display word, committing it only at
//           the frame boundary so a frame never shows a mix of old and new nibbles.
// Latency : every output is registered and shows the internal scan state one cycle late;
//           o_frameDone pulses on the cycle the commit takes place.
// Backpressure: none -- i_valid is a fire-and-forget strobe; later strobes before the commit
//           overwrite the pending word (last wins).
//
// Ports:
//   i_clk          system clock, all logic on the rising edge
//   i_reset        synchronous, active-high reset
//   i_enable       1 = scanning, 0 = display dark (FSM parked at digit 0, ON, counter 0)
//   i_valid        1-cycle strobe capturing i_value into the pending buffer
//   i_value[15:0]  display word, nibble n -> digit n (digit 0 = [3:0])
//   o_digitSelect  current digit index (to FND_Select_Decoder)
//   o_value[3:0]   committed nibble for the current digit (to BCDtoFND_Decoder)
//   o_en           1 while the digit is lit
//   o_pending      1 while a captured word waits for the frame boundary
//   o_frameDone    1-cycle pulse when the digit-3 slot (including its gap) ends
//
// Build option: define LEADING_ZERO_BLANK_EN to darken digits above the most-significant
// nonzero nibble of the committed word (digit 0 always lit). Slot timing is unchanged.

module fnd_scan_controller #(
  parameter int TICK_DIV   = 100_000,  // cycles a digit is lit per slot (>= 1)
  parameter int GAP_CYCLES = 8         // dark cycles after each lit slot (0 = no gap)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_valid,
  input  logic [15:0] i_value,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_value,
  output logic        o_en,
  output logic        o_pending,
  output logic        o_frameDone
);

  // One counter serves both phases, so it is sized for the longer of the two.
  localparam int CNT_MAX = (TICK_DIV > GAP_CYCLES) ? TICK_DIV : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] ON_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam bit            HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic {
    S_ON  = 1'b0,
    S_GAP = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      digit, digit_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [15:0]     committed, committed_nxt;
  logic [15:0]     pending, pending_nxt;
  logic            flag, flag_nxt;
  logic            slot_end;
  logic            wrap;
  logic [3:0]      cur_nibble;
  logic            lit;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_ON;
      digit     <= 2'd0;
      cnt       <= '0;
      committed <= 16'h0;
      pending   <= 16'h0;
      flag      <= 1'b0;
    end else begin
      state     <= state_nxt;
      digit     <= digit_nxt;
      cnt       <= cnt_nxt;
      committed <= committed_nxt;
      pending   <= pending_nxt;
      flag      <= flag_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: scan sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    cnt_nxt   = cnt;
    slot_end  = 1'b0;

    if (!i_enable) begin
      // Parked so that re-enabling restarts a clean frame from digit 0.
      state_nxt = S_ON;
      digit_nxt = 2'd0;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        S_ON: begin
          if (cnt == ON_LAST) begin
            cnt_nxt = '0;
            if (HAS_GAP) begin
              state_nxt = S_GAP;
            end else begin
              // No gap configured: the slot ends with the lit phase.
              digit_nxt = digit + 2'd1;
              slot_end  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state_nxt = S_ON;
            digit_nxt = digit + 2'd1;
            cnt_nxt   = '0;
            slot_end  = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = S_ON;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Frame boundary: the digit-3 slot finishes and the scan wraps to digit 0.
    wrap = slot_end && (digit == 2'd3);
  end

  // ---------------------------------------------------------------------------
  // Next-state: double buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    committed_nxt = committed;
    pending_nxt   = pending;
    flag_nxt      = flag;

    if (!i_enable) begin
      // Display is dark, so there is no frame to tear: apply the word at once.
      if (i_valid) begin
        committed_nxt = i_value;
        pending_nxt   = i_value;
        flag_nxt      = 1'b0;
      end
    end else if (wrap) begin
      flag_nxt = 1'b0;
      if (i_valid) begin
        // A strobe landing on the boundary goes straight to the display.
        committed_nxt = i_value;
        pending_nxt   = i_value;
      end else begin
        committed_nxt = pending;
      end
    end else if (i_valid) begin
      pending_nxt = i_value;
      flag_nxt    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Nibble of the committed word for the digit being scanned
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_nibble = committed[3:0];
    case (digit)
      2'd0:    cur_nibble = committed[3:0];
      2'd1:    cur_nibble = committed[7:4];
      2'd2:    cur_nibble = committed[11:8];
      default: cur_nibble = committed[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Highest digit worth lighting; an all-zero word still shows a single "0".
  logic [1:0] top_digit;

  always_comb begin
    top_digit = 2'd0;
    if (|committed[7:4])   top_digit = 2'd1;
    if (|committed[11:8])  top_digit = 2'd2;
    if (|committed[15:12]) top_digit = 2'd3;
    lit = (digit <= top_digit);
  end
`else
  assign lit = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_digitSelect <= 2'd0;
      o_value       <= 4'h0;
      o_en          <= 1'b0;
      o_pending     <= 1'b0;
      o_frameDone   <= 1'b0;
    end else begin
      o_digitSelect <= digit;
      o_value       <= cur_nibble;
      o_en          <= i_enable && (state == S_ON) && lit;
      o_pending     <= flag;
      o_frameDone   <= wrap;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Purpose : self-checking bench for fnd_scan_controller (TICK_DIV=4 with GAP_CYCLES=2 and 0).
// Latency : outputs sampled on the falling edge, one cycle index per clock.
// Backpressure: not applicable; the DUT has no ready path.

module tb_fnd_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: TICK_DIV=4, GAP_CYCLES=2
  logic        a_reset, a_enable, a_valid;
  logic [15:0] a_value;
  logic [1:0]  a_dig;
  logic [3:0]  a_val;
  logic        a_en, a_pend, a_fd;

  // DUT B: TICK_DIV=4, GAP_CYCLES=0
  logic        b_reset, b_enable, b_valid;
  logic [15:0] b_value;
  logic [1:0]  b_dig;
  logic [3:0]  b_val;
  logic        b_en, b_pend, b_fd;

  fnd_scan_controller #(.TICK_DIV(4), .GAP_CYCLES(2)) u_a (
    .i_clk(clk), .i_reset(a_reset), .i_enable(a_enable), .i_valid(a_valid),
    .i_value(a_value), .o_digitSelect(a_dig), .o_value(a_val), .o_en(a_en),
    .o_pending(a_pend), .o_frameDone(a_fd)
  );

  fnd_scan_controller #(.TICK_DIV(4), .GAP_CYCLES(0)) u_b (
    .i_clk(clk), .i_reset(b_reset), .i_enable(b_enable), .i_valid(b_valid),
    .i_value(b_value), .o_digitSelect(b_dig), .o_value(b_val), .o_en(b_en),
    .o_pending(b_pend), .o_frameDone(b_fd)
  );

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  // Scoreboard: expected output runs {digit, en, value, length} and frameDone cycles.
  logic [31:0] exp_q[$];
  int          fd_q[$];
  logic [6:0]  last_run;
  int          run_len;
  bit          have_run;
  bit          mon_on;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, ncyc, got, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] w, input int d);
    return w[d*4 +: 4];
  endfunction

  function automatic bit digit_lit(input logic [15:0] w, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    int top;
    top = 0;
    for (int i = 1; i < 4; i++) if (nib(w, i) != 4'h0) top = i;
    return d <= top;
`else
    return 1'b1;
`endif
  endfunction

  // One frame of DUT A: lit 4 + dark 2 per digit; a blanked digit is one dark run of 6.
  task automatic push_frame(input logic [15:0] w);
    for (int d = 0; d < 4; d++) begin
      logic [1:0] dd;
      dd = d[1:0];
      if (digit_lit(w, d)) begin
        exp_q.push_back({17'd0, dd, 1'b1, nib(w, d), 8'd4});
        exp_q.push_back({17'd0, dd, 1'b0, nib(w, d), 8'd2});
      end else begin
        exp_q.push_back({17'd0, dd, 1'b0, nib(w, d), 8'd6});
      end
    end
  endtask

  task automatic mon_a();
    logic [6:0] cur;
    cur = {a_dig, a_en, a_val};
    if (a_fd) begin
      if (fd_q.size() == 0) check("a_fd_extra", ncyc, 0);
      else                  check("a_frame_done", ncyc, fd_q.pop_front());
    end
    if (have_run && cur == last_run) begin
      run_len++;
    end else begin
      if (have_run) begin
        if (exp_q.size() == 0) check("a_run_extra", {17'd0, last_run, run_len[7:0]}, 32'd0);
        else check("a_run", {17'd0, last_run, run_len[7:0]}, exp_q.pop_front());
      end
      last_run = cur;
      run_len  = 1;
      have_run = 1'b1;
    end
  endtask

  task automatic b_checks(input int k);
    logic [1:0] d;
    logic [3:0] v;
    if (k <= 40) begin
      d = 2'(((k - 1) / 4) % 4);
      v = (k >= 17) ? nib(16'h9876, int'(d)) : 4'h0;
      check("b_scan", {25'd0, b_dig, b_en, b_val}, {25'd0, d, 1'b1, v});
    end
    case (k)
      16: check("b_frame_done", 32'(b_fd), 32'd1);
      17: check("b_frame_done_clr", 32'(b_fd), 32'd0);
      42: check("b_pending", 32'(b_pend), 32'd1);
      43: check("b_reset_mid", {23'd0, b_dig, b_en, b_val, b_pend, b_fd}, 32'd0);
      47: check("b_restart", {25'd0, b_dig, b_en, b_val}, {25'd0, 2'd0, 1'b1, 4'h0});
      55: check("b_digit2", {29'd0, b_dig, b_en}, {29'd0, 2'd2, 1'b1});
      61: check("b_frame_done2", 32'(b_fd), 32'd1);
      63: check("b_discard", {25'd0, b_dig, b_en, b_val}, {25'd0, 2'd0, 1'b1, 4'h0});
      default: ;
    endcase
  endtask

  task automatic a_checks(input int k);
    case (k)
      33:  check("a_pending_set", 32'(a_pend), 32'd1);
      50:  check("a_pending_clr", 32'(a_pend), 32'd0);
      102: check("a_pending_set2", 32'(a_pend), 32'd1);
      121: check("a_bypass_pending", 32'(a_pend), 32'd0);
      203: begin
        check("a_disable", {29'd0, a_dig, a_en}, 32'd0);
        check("a_disable_pending", 32'(a_pend), 32'd1);
      end
      206: check("a_disable_commit", 32'(a_pend), 32'd0);
      default: ;
    endcase
  endtask

  initial begin
    a_reset = 1'b1; a_enable = 1'b0; a_valid = 1'b0; a_value = 16'h0;
    b_reset = 1'b1; b_enable = 1'b0; b_valid = 1'b0; b_value = 16'h0;
    mon_on = 1'b0; have_run = 1'b0; run_len = 0; last_run = '0;
    repeat (3) @(negedge clk);
    check("a_reset_state", {27'd0, a_dig, a_en, a_val[1:0], a_pend, a_fd} | {28'd0, a_val}, 32'd0);
    check("b_reset_state", {23'd0, b_dig, b_en, b_val, b_pend, b_fd}, 32'd0);

    // Frames as committed: 0, 0, 1234, 1234, 5A5F, 0C0D (bypass), 0050, 0000.
    push_frame(16'h0000); push_frame(16'h0000);
    push_frame(16'h1234); push_frame(16'h1234);
    push_frame(16'h5A5F); push_frame(16'h0C0D);
    push_frame(16'h0050); push_frame(16'h0000);
    for (int f = 1; f <= 8; f++) fd_q.push_back(24 * f);

    a_reset = 1'b0; a_enable = 1'b1;
    b_reset = 1'b0; b_enable = 1'b1;
    mon_on = 1'b1;

    for (int k = 1; k <= 233; k++) begin
      @(negedge clk);
      ncyc = k;
      if (mon_on) mon_a();
      a_checks(k);
      b_checks(k);
      a_valid = 1'b0;
      b_valid = 1'b0;
      case (k)
        2:   begin b_valid = 1'b1; b_value = 16'h9876; end
        30:  begin a_valid = 1'b1; a_value = 16'h1234; end
        40:  begin b_valid = 1'b1; b_value = 16'h4444; end
        42:  b_reset = 1'b1;
        45:  b_reset = 1'b0;
        75:  begin a_valid = 1'b1; a_value = 16'hAAAA; end
        80:  begin a_valid = 1'b1; a_value = 16'h5A5F; end
        100: begin a_valid = 1'b1; a_value = 16'h1111; end
        119: begin a_valid = 1'b1; a_value = 16'h0C0D; end
        130: begin a_valid = 1'b1; a_value = 16'h0050; end
        150: begin a_valid = 1'b1; a_value = 16'h0000; end
        193: mon_on = 1'b0;
        196: begin a_valid = 1'b1; a_value = 16'h7777; end
        200: a_enable = 1'b0;
        204: begin a_valid = 1'b1; a_value = 16'h0F00; end
        208: begin
          a_enable = 1'b1;
          have_run = 1'b0;
          mon_on   = 1'b1;
          push_frame(16'h0F00);
          fd_q.push_back(232);
        end
        default: ;
      endcase
    end

    check("a_runs_left", 32'(exp_q.size()), 32'd0);
    check("a_fd_left", 32'(fd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
